// File: rtl/mem_line_if.sv
// mem_line_if: line request / response bundle between a direct-mapped cache
// (master) and its main-memory responder (slave).
//
// Signals:
//   req_valid / req_ready   request handshake (master -> slave, slave -> master)
//   req_we                  1 = full-line writeback, 0 = line read for fill
//   req_addr                line address
//   req_wdata               write line, word i at [i*WORD_W +: WORD_W]
//   rsp_valid / rsp_last    response beat valid / final beat
//   rsp_idx                 word index of the current beat
//   rsp_data                read word (0 on write ack and when idle)
//   rsp_par                 XOR of rsp_data, present only with MEMRSP_PARITY_EN
interface mem_line_if #(
    parameter int ADDR_W     = 8,
    parameter int WORD_W     = 32,
    parameter int LINE_WORDS = 4
);
    localparam int IDX_W = $clog2(LINE_WORDS);

    logic                         req_valid;
    logic                         req_ready;
    logic                         req_we;
    logic [ADDR_W-1:0]            req_addr;
    logic [LINE_WORDS*WORD_W-1:0] req_wdata;
    logic                         rsp_valid;
    logic                         rsp_last;
    logic [IDX_W-1:0]             rsp_idx;
    logic [WORD_W-1:0]            rsp_data;
`ifdef MEMRSP_PARITY_EN
    logic                         rsp_par;
`endif

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_last, rsp_idx, rsp_data
`ifdef MEMRSP_PARITY_EN
        , input rsp_par
`endif
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_last, rsp_idx, rsp_data
`ifdef MEMRSP_PARITY_EN
        , output rsp_par
`endif
    );
endinterface

// File: rtl/mem_line_responder.sv
// mem_line_responder: memory end of the cache fill/writeback path.
// Holds 2**ADDR_W lines of LINE_WORDS words. One request at a time:
// a write commits the whole line at acceptance and answers with a single ack
// beat LATENCY cycles later; a read snapshots the line at acceptance and
// streams it word by word starting LATENCY cycles later. No response
// backpressure.
//
// Ports:
//   clk    clock, all state on rising edge
//   rst_n  asynchronous active-low reset (storage array is not reset)
//   bus    mem_line_if.slave request/response bundle
//   busy   request in progress
//
// Optional macro MEMRSP_PARITY_EN adds bus.rsp_par = ^rsp_data.
module mem_line_responder #(
    parameter int ADDR_W     = 8,
    parameter int WORD_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int LATENCY    = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    mem_line_if.slave bus,
    output logic     busy
);
    localparam int IDX_W  = $clog2(LINE_WORDS);
    localparam int LAT_W  = $clog2(LATENCY + 1);
    localparam int LINE_W = LINE_WORDS * WORD_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, WAIT, BURST, WACK} state_t;

    logic [LINE_W-1:0] mem [0:(2**ADDR_W)-1];

    state_t            state_reg;
    logic [LAT_W-1:0]  lat_cnt_reg;
    logic [IDX_W-1:0]  beat_reg;
    logic              we_reg;
    logic [LINE_W-1:0] line_reg;
    logic              rsp_valid_reg;
    logic              rsp_last_reg;
    logic [WORD_W-1:0] rsp_data_reg;
    logic              rsp_par_reg;

    logic              accept;
    logic              start;
    logic              start_we;
    logic [WORD_W-1:0] first_word;
    logic [IDX_W-1:0]  beat_inc;
    logic              valid_next;
    logic              last_next;
    logic [WORD_W-1:0] data_next;
    logic [WORD_W-1:0] line_words [LINE_WORDS];

    assign accept   = bus.req_valid && (state_reg == IDLE);
    assign beat_inc = beat_reg + IDX_W'(1);

    generate
        for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_words
            assign line_words[gi] = line_reg[gi*WORD_W +: WORD_W];
        end
    endgenerate

    // With LATENCY==1 the first beat is launched at the acceptance edge,
    // before the line buffer holds the snapshot, so word 0 comes straight
    // from the array read that also loads the buffer.
    generate
        if (LATENCY == 1) begin : g_lat1
            logic [LINE_W-1:0] rd_line;
            assign rd_line    = mem[bus.req_addr];
            assign first_word = (state_reg == IDLE) ? rd_line[WORD_W-1:0] : line_words[0];
            assign start      = accept;
        end else begin : g_latn
            assign first_word = line_words[0];
            assign start      = (state_reg == WAIT) && (lat_cnt_reg <= LAT_W'(1));
        end
    endgenerate

    assign start_we = (state_reg == IDLE) ? bus.req_we : we_reg;

    // Next response beat; registered below so all rsp_* outputs are flops.
    always_comb begin
        valid_next = 1'b0;
        last_next  = 1'b0;
        data_next  = '0;
        if (start) begin
            valid_next = 1'b1;
            if (start_we) begin
                last_next = 1'b1;
            end else begin
                data_next = first_word;
            end
        end else if ((state_reg == BURST) && (beat_reg != LAST_IDX)) begin
            valid_next = 1'b1;
            data_next  = line_words[beat_inc];
            last_next  = (beat_inc == LAST_IDX);
        end
    end

    // Storage: written at acceptance, never reset.
    always_ff @(posedge clk) begin
        if (accept && bus.req_we) begin
            mem[bus.req_addr] <= bus.req_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            lat_cnt_reg   <= '0;
            beat_reg      <= '0;
            we_reg        <= 1'b0;
            line_reg      <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_last_reg  <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_par_reg   <= 1'b0;
        end else begin
            rsp_valid_reg <= valid_next;
            rsp_last_reg  <= last_next;
            rsp_data_reg  <= data_next;
            rsp_par_reg   <= ^data_next;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        we_reg   <= bus.req_we;
                        // Read-before-write: on a write the snapshot is unused.
                        line_reg <= mem[bus.req_addr];
                        beat_reg <= '0;
                        if (LATENCY == 1) begin
                            state_reg <= bus.req_we ? WACK : BURST;
                        end else begin
                            state_reg   <= WAIT;
                            lat_cnt_reg <= LAT_W'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    // Leaving at count 1 lands the first registered beat
                    // exactly LATENCY cycles after acceptance.
                    if (lat_cnt_reg <= LAT_W'(1)) begin
                        state_reg   <= we_reg ? WACK : BURST;
                        lat_cnt_reg <= '0;
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg - LAT_W'(1);
                    end
                end
                BURST: begin
                    if (beat_reg == LAST_IDX) begin
                        state_reg <= IDLE;
                        beat_reg  <= '0;
                    end else begin
                        beat_reg <= beat_inc;
                    end
                end
                WACK: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = (state_reg == IDLE);
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_last  = rsp_last_reg;
    assign bus.rsp_idx   = beat_reg;
    assign bus.rsp_data  = rsp_data_reg;
    assign busy          = (state_reg != IDLE);
`ifdef MEMRSP_PARITY_EN
    assign bus.rsp_par   = rsp_par_reg;
`else
    logic unused_par;
    assign unused_par = rsp_par_reg;
`endif
endmodule

// File: doc/mem_line_responder.md
Name: mem_line_responder

Overview:
- Main-memory responder: the memory end of the direct-mapped cache's fill/writeback interface.
- Accepts one line request at a time (full-line writeback, or line read for fill).
- Write returns a single ack beat after a fixed latency; read returns the line as a word-per-cycle burst after the same latency.
- Holds the line storage array internally; used as the backing store under the cache in simulation and FPGA builds.

Parameters:
- ADDR_W, 8, line-address width; array depth 2**ADDR_W lines.
- WORD_W, 32, data word width.
- LINE_WORDS, 4, words per line; power of 2, >= 2.
- LATENCY, 4, cycles from request acceptance to first response beat; >= 1.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder idle, can accept.
- req_we  in  1  1 = line write (writeback), 0 = line read (fill).
- req_addr  in  ADDR_W  line address.
- req_wdata  in  LINE_WORDS*WORD_W  write line; word i at [i*WORD_W +: WORD_W].
- rsp_valid  out  1  response beat valid.
- rsp_last  out  1  final beat of response.
- rsp_idx  out  log2(LINE_WORDS)  word index of current beat.
- rsp_data  out  WORD_W  read word; 0 on write ack and when rsp_valid=0.
- busy  out  1  request in progress (state != IDLE).

Behaviour:
- Reset (rst_n=0, async):
  - State goes to IDLE immediately.
  - req_ready=1; rsp_valid, rsp_last, rsp_idx, rsp_data, busy all 0.
  - Latency and beat counters cleared; line buffer cleared.
  - Storage array is not reset; contents survive reset. A read of a never-written line returns an undefined value.
- States: IDLE, WAIT, BURST, WACK.
- Acceptance: req_valid && req_ready at edge T. req_ready=1 only in IDLE; req_valid while not ready is ignored (no queueing).
- On acceptance, transition IDLE->WAIT with latency counter = LATENCY-1; record req_we.
  - Write: array[req_addr] <= req_wdata at edge T.
  - Read: array[req_addr] snapshot into line buffer at edge T.
- A read accepted after a write to the same line sees the written data.
- WAIT: counter decrements each cycle; at 0, go to BURST (read) or WACK (write). First beat appears in cycle T+LATENCY.
- BURST (read):
  - Beats in cycles T+LATENCY .. T+LATENCY+LINE_WORDS-1, one per cycle, no gaps.
  - rsp_idx = 0..LINE_WORDS-1 ascending; rsp_data = line buffer word rsp_idx.
  - rsp_last=1 only on idx LINE_WORDS-1. After the last beat, go to IDLE.
- WACK (write): single beat in cycle T+LATENCY with rsp_valid=1, rsp_last=1, rsp_idx=0, rsp_data=0; then IDLE.
- Response path has no backpressure; the consumer must sink every beat.
- req_ready returns in the cycle after the last beat (T+LATENCY+LINE_WORDS for read, T+LATENCY+1 for write). A request held valid is accepted that cycle, giving back-to-back service.
- Counter widths: latency counter ceil(log2(LATENCY+1)); beat counter log2(LINE_WORDS), wraps to 0 after last beat.
- Reset asserted mid-WAIT or mid-BURST aborts the request. A write already accepted remains committed in the array.

Optional Feature:
- Macro MEMRSP_PARITY_EN.
- Defined: adds output port rsp_par (1 bit) = XOR-reduction of rsp_data, registered alongside rsp_data; 0 when rsp_valid=0 and on write ack; reset 0.
- Undefined: port absent, no parity logic.

Test Plan:
- Reset: pulse rst_n low mid-cycle -> outputs drop immediately; req_ready=1, rsp_valid=0, busy=0 until the first request.
- Write, LATENCY=4, LINE_WORDS=4:
  - Stimulus: accept at T, addr 0x12, words 0x11111111, 0x22222222, 0x33333333, 0x44444444.
  - Response: single beat at T+4 with rsp_last=1, rsp_data=0; busy T+1..T+4; req_ready=1 at T+5.
- Read 0x12 accepted at T:
  - Beats T+4..T+7, idx 0..3, data 0x11111111..0x44444444; rsp_last only at T+7.
  - req_ready=1 at T+8.
- Back-to-back: hold req_valid with a read of 0x12 during a write burst -> second request accepted exactly in the cycle req_ready returns; no request lost or duplicated.
- Reset during BURST at beat idx 1 -> rsp_valid drops asynchronously; after release, a new read of 0x12 returns the full original line.
- With MEMRSP_PARITY_EN: read line containing 0x11111111 and 0x00000007 -> rsp_par=0 and 1 on those beats respectively.
